// File: rtl/trim_rx.sv
// trim_rx: oversampling receiver for the serial trim link; deserializes LSB-first frames closed by ENCLK idle gaps.
// Optional build macro: TRIM_RX_SEQ_CHECK_EN enables the consecutive-code sequence check on ERR_SEQ.
module trim_rx #(
   parameter int WIDTH       = 12,
   parameter int SYNC_STAGES = 2,
   parameter int GAP_CYCLES  = 64
) (
   input  logic             CLK50,
   input  logic             RST_N,
   input  logic             ENCLK,
   input  logic             DIN,
   output logic [WIDTH-1:0] TRIMCODE,
   output logic             VALID,
   output logic             ERR_SHORT,
   output logic             ERR_OVR,
   output logic             ERR_SEQ,
   output logic [7:0]       FRAME_CNT,
   output logic             BUSY
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_ERR  = 2'd2
   } state_t;

   logic [SYNC_STAGES-1:0] enclk_sync_r;
   logic [SYNC_STAGES-1:0] din_sync_r;
   logic                   enclk_prev_r;
   logic                   enclk_s;
   logic                   din_s;
   logic                   rise_s;
   logic [GW-1:0]          gap_cnt_r;
   logic                   gap_hit_s;
   logic                   armed_r;
   logic                   rx_rise_s;

   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [WIDTH-1:0]       shreg_r;
   logic [WIDTH-1:0]       shreg_nxt_s;
   logic [CW-1:0]          bit_cnt_r;
   logic [CW-1:0]          bit_cnt_nxt_s;
   logic                   commit_s;
   logic                   short_s;
   logic                   ovr_s;

   function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic bit_in);
      shift_in = {bit_in, cur[WIDTH-1:1]};
   endfunction

   // Equal-depth synchronizers keep DIN aligned with the ENCLK edge it belongs to.
   always_ff @(posedge CLK50) begin
      if (!RST_N) begin
         enclk_sync_r <= '0;
         din_sync_r   <= '0;
         enclk_prev_r <= 1'b0;
      end else begin
         enclk_sync_r <= {enclk_sync_r[SYNC_STAGES-2:0], ENCLK};
         din_sync_r   <= {din_sync_r[SYNC_STAGES-2:0], DIN};
         enclk_prev_r <= enclk_sync_r[SYNC_STAGES-1];
      end
   end

   assign enclk_s   = enclk_sync_r[SYNC_STAGES-1];
   assign din_s     = din_sync_r[SYNC_STAGES-1];
   assign rise_s    = enclk_s & ~enclk_prev_r;
   assign gap_hit_s = ~rise_s & (gap_cnt_r == GW'(GAP_CYCLES - 1));
   assign rx_rise_s = rise_s & armed_r;

   // Idle-gap counter saturates so gap_hit fires once per gap; ARMED waits for the first full gap.
   always_ff @(posedge CLK50) begin
      if (!RST_N) begin
         gap_cnt_r <= '0;
         armed_r   <= 1'b0;
      end else begin
         if (rise_s) begin
            gap_cnt_r <= '0;
         end else if (gap_cnt_r != GW'(GAP_CYCLES)) begin
            gap_cnt_r <= gap_cnt_r + GW'(1);
         end else begin
            gap_cnt_r <= gap_cnt_r;
         end
         if (gap_hit_s) begin
            armed_r <= 1'b1;
         end else begin
            armed_r <= armed_r;
         end
      end
   end

   // Frame FSM next-state and event decode.
   always_comb begin
      state_nxt_s   = state_r;
      shreg_nxt_s   = shreg_r;
      bit_cnt_nxt_s = bit_cnt_r;
      commit_s      = 1'b0;
      short_s       = 1'b0;
      ovr_s         = 1'b0;
      case (state_r)
         ST_IDLE: begin
            bit_cnt_nxt_s = '0;
            if (rx_rise_s) begin
               shreg_nxt_s   = shift_in(shreg_r, din_s);
               bit_cnt_nxt_s = CW'(1);
               state_nxt_s   = ST_RECV;
            end else begin
               state_nxt_s   = ST_IDLE;
            end
         end
         ST_RECV: begin
            if (rx_rise_s) begin
               if (bit_cnt_r < CW'(WIDTH)) begin
                  shreg_nxt_s   = shift_in(shreg_r, din_s);
                  bit_cnt_nxt_s = bit_cnt_r + CW'(1);
               end else begin
                  ovr_s       = 1'b1;
                  state_nxt_s = ST_ERR;
               end
            end else if (gap_hit_s) begin
               state_nxt_s = ST_IDLE;
               if (bit_cnt_r == CW'(WIDTH)) begin
                  commit_s = 1'b1;
               end else begin
                  short_s  = 1'b1;
               end
            end else begin
               state_nxt_s = ST_RECV;
            end
         end
         ST_ERR: begin
            if (gap_hit_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ERR;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            bit_cnt_nxt_s = '0;
         end
      endcase
   end

   // State, datapath and registered outputs.
   always_ff @(posedge CLK50) begin
      if (!RST_N) begin
         state_r   <= ST_IDLE;
         shreg_r   <= '0;
         bit_cnt_r <= '0;
         TRIMCODE  <= '0;
         VALID     <= 1'b0;
         ERR_SHORT <= 1'b0;
         ERR_OVR   <= 1'b0;
         FRAME_CNT <= 8'd0;
         BUSY      <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         shreg_r   <= shreg_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         VALID     <= commit_s;
         ERR_SHORT <= short_s;
         ERR_OVR   <= ovr_s;
         BUSY      <= (state_nxt_s != ST_IDLE);
         if (commit_s) begin
            TRIMCODE  <= shreg_r;
            FRAME_CNT <= FRAME_CNT + 8'd1;
         end else begin
            TRIMCODE  <= TRIMCODE;
            FRAME_CNT <= FRAME_CNT;
         end
      end
   end

`ifdef TRIM_RX_SEQ_CHECK_EN
   logic [WIDTH-1:0] seq_ref_r;
   logic             seq_first_r;
   logic [WIDTH-1:0] seq_exp_s;

   assign seq_exp_s = seq_ref_r + WIDTH'(1);

   // Each commit after the first must equal the previous committed code plus one.
   always_ff @(posedge CLK50) begin
      if (!RST_N) begin
         seq_ref_r   <= '0;
         seq_first_r <= 1'b1;
         ERR_SEQ     <= 1'b0;
      end else begin
         if (commit_s) begin
            seq_ref_r   <= shreg_r;
            seq_first_r <= 1'b0;
            ERR_SEQ     <= ~seq_first_r & (shreg_r != seq_exp_s);
         end else begin
            seq_ref_r   <= seq_ref_r;
            seq_first_r <= seq_first_r;
            ERR_SEQ     <= 1'b0;
         end
      end
   end
`else
   assign ERR_SEQ = 1'b0;
`endif

endmodule

// File: tb/tb_trim_rx.sv
// Directed self-checking bench for trim_rx; expected values are hand-computed per step.
module tb_trim_rx;

   logic        CLK50 = 1'b0;
   logic        RST_N = 1'b0;
   logic        ENCLK = 1'b0;
   logic        DIN   = 1'b0;
   logic [11:0] TRIMCODE;
   logic        VALID;
   logic        ERR_SHORT;
   logic        ERR_OVR;
   logic        ERR_SEQ;
   logic [7:0]  FRAME_CNT;
   logic        BUSY;

   int errors = 0;
   int checks = 0;
   int n_valid = 0, n_short = 0, n_ovr = 0, n_seq = 0, n_clash = 0;
   int b_valid, b_short, b_ovr, b_seq;
   int cyc;

   trim_rx dut (
      .CLK50     (CLK50),
      .RST_N     (RST_N),
      .ENCLK     (ENCLK),
      .DIN       (DIN),
      .TRIMCODE  (TRIMCODE),
      .VALID     (VALID),
      .ERR_SHORT (ERR_SHORT),
      .ERR_OVR   (ERR_OVR),
      .ERR_SEQ   (ERR_SEQ),
      .FRAME_CNT (FRAME_CNT),
      .BUSY      (BUSY)
   );

   always #10 CLK50 = ~CLK50;

   // Pulse counters sampled on the falling edge.
   always @(negedge CLK50) begin
      if (VALID)     n_valid++;
      if (ERR_SHORT) n_short++;
      if (ERR_OVR)   n_ovr++;
      if (ERR_SEQ)   n_seq++;
      if (VALID && (ERR_SHORT || ERR_OVR)) n_clash++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic snap();
      b_valid = n_valid;
      b_short = n_short;
      b_ovr   = n_ovr;
      b_seq   = n_seq;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK50);
      #1;
   endtask

   task automatic send_bits(input logic [11:0] code, input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK50);
         #1 DIN = (i < 12) ? code[i] : 1'b0;
         repeat (4) @(posedge CLK50);
         #1 ENCLK = 1'b1;
         repeat (4) @(posedge CLK50);
         #1 ENCLK = 1'b0;
      end
   endtask

   // Counts falling edges from the end of the last bit until VALID, bounded.
   task automatic wait_valid(output int c);
      c = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK50);
         c++;
         if (VALID) break;
      end
   endtask

   task automatic frame(input logic [11:0] code, output int c);
      send_bits(code, 12);
      check("busy_in_frame", 32'(BUSY), 32'd1);
      wait_valid(c);
   endtask

   task automatic do_reset();
      @(posedge CLK50);
      #1 RST_N = 1'b0;
      repeat (3) @(posedge CLK50);
      #1 RST_N = 1'b1;
   endtask

   logic [11:0] seq_codes [5];
   logic        seq_exp   [5];

   initial begin
      // Reset state
      RST_N = 1'b0;
      repeat (3) @(posedge CLK50);
      @(negedge CLK50);
      check("rst_trimcode",  32'(TRIMCODE),  32'h0);
      check("rst_valid",     32'(VALID),     32'h0);
      check("rst_err_short", 32'(ERR_SHORT), 32'h0);
      check("rst_err_ovr",   32'(ERR_OVR),   32'h0);
      check("rst_err_seq",   32'(ERR_SEQ),   32'h0);
      check("rst_frame_cnt", 32'(FRAME_CNT), 32'h0);
      check("rst_busy",      32'(BUSY),      32'h0);
      @(posedge CLK50);
      #1 RST_N = 1'b1;
      idle(70);

      // Good frame 0x5A3: commit 64 cycles after the last detected rise
      snap();
      frame(12'h5A3, cyc);
      check("t1_latency",   32'(cyc),       32'd64);
      check("t1_trimcode",  32'(TRIMCODE),  32'h5A3);
      check("t1_frame_cnt", 32'(FRAME_CNT), 32'd1);
      @(negedge CLK50);
      check("t1_valid_one_cycle", 32'(VALID), 32'd0);
      check("t1_busy_low",        32'(BUSY),  32'd0);
      check("t1_valid_count", 32'(n_valid - b_valid), 32'd1);

      // ENCLK bursting across reset release must not be captured
      @(posedge CLK50);
      #1 RST_N = 1'b0;
      send_bits(12'hAAA, 4);
      check("t2_trimcode_rst", 32'(TRIMCODE), 32'h0);
      snap();
      RST_N = 1'b1;
      send_bits(12'h555, 5);
      idle(80);
      check("t2_no_valid", 32'(n_valid - b_valid), 32'd0);
      check("t2_no_short", 32'(n_short - b_short), 32'd0);
      check("t2_no_ovr",   32'(n_ovr - b_ovr),     32'd0);
      check("t2_trimcode_hold", 32'(TRIMCODE), 32'h0);
      frame(12'h001, cyc);
      check("t2_trimcode",  32'(TRIMCODE),  32'h001);
      check("t2_frame_cnt", 32'(FRAME_CNT), 32'd1);
      idle(4);
      check("t2_err_after", 32'((n_short - b_short) + (n_ovr - b_ovr)), 32'd0);

      // Short frame of 7 edges
      snap();
      send_bits(12'h07F, 7);
      idle(80);
      check("t3_short_count", 32'(n_short - b_short), 32'd1);
      check("t3_no_valid",    32'(n_valid - b_valid), 32'd0);
      check("t3_trimcode",    32'(TRIMCODE),  32'h001);
      check("t3_frame_cnt",   32'(FRAME_CNT), 32'd1);

      // Overrun frame of 13 edges, then a good 0xFFF
      snap();
      send_bits(12'hFFF, 13);
      check("t4_ovr_on_13th", 32'(n_ovr - b_ovr), 32'd1);
      check("t4_busy_err",    32'(BUSY), 32'd1);
      idle(80);
      check("t4_no_valid", 32'(n_valid - b_valid), 32'd0);
      check("t4_no_short", 32'(n_short - b_short), 32'd0);
      check("t4_ovr_once", 32'(n_ovr - b_ovr),     32'd1);
      check("t4_busy_idle", 32'(BUSY), 32'd0);
      frame(12'hFFF, cyc);
      check("t4_trimcode",  32'(TRIMCODE),  32'hFFF);
      check("t4_frame_cnt", 32'(FRAME_CNT), 32'd2);

      // Reset after the 6th edge of a frame
      send_bits(12'h800, 6);
      @(posedge CLK50);
      #1 RST_N = 1'b0;
      repeat (2) @(negedge CLK50);
      check("t5_trimcode_rst",  32'(TRIMCODE),  32'h0);
      check("t5_frame_cnt_rst", 32'(FRAME_CNT), 32'd0);
      check("t5_busy_rst",      32'(BUSY),      32'd0);
      @(posedge CLK50);
      #1 RST_N = 1'b1;
      idle(80);
      frame(12'h800, cyc);
      check("t5_trimcode",  32'(TRIMCODE),  32'h800);
      check("t5_frame_cnt", 32'(FRAME_CNT), 32'd1);

      // Sequence check over five frames
      seq_codes[0] = 12'h010; seq_codes[1] = 12'h011; seq_codes[2] = 12'h013;
      seq_codes[3] = 12'hFFF; seq_codes[4] = 12'h000;
`ifdef TRIM_RX_SEQ_CHECK_EN
      seq_exp[0] = 1'b0; seq_exp[1] = 1'b0; seq_exp[2] = 1'b1; seq_exp[3] = 1'b1; seq_exp[4] = 1'b0;
`else
      seq_exp[0] = 1'b0; seq_exp[1] = 1'b0; seq_exp[2] = 1'b0; seq_exp[3] = 1'b0; seq_exp[4] = 1'b0;
`endif
      do_reset();
      idle(80);
      snap();
      for (int f = 0; f < 5; f++) begin
         frame(seq_codes[f], cyc);
         check($sformatf("t6_code_%0d", f), 32'(TRIMCODE), 32'(seq_codes[f]));
         check($sformatf("t6_seq_%0d", f),  32'(ERR_SEQ),  32'(seq_exp[f]));
      end
      idle(4);
      check("t6_frame_cnt", 32'(FRAME_CNT), 32'd5);
`ifdef TRIM_RX_SEQ_CHECK_EN
      check("t6_seq_count", 32'(n_seq - b_seq), 32'd2);
`else
      check("t6_seq_count", 32'(n_seq - b_seq), 32'd0);
`endif
      check("no_err_with_valid", 32'(n_clash), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
